// File: rtl/maze_player_mover.sv
// Player position tracker: steps one cell per key press using the maze move-constraint maps.
// Optional auto-repeat while a direction is held is enabled by defining MAZE_MOVE_REPEAT_EN.
module maze_player_mover #(
    parameter int size_y        = 20,
    parameter int size_x        = 40,
    parameter int START_X       = 0,
    parameter int START_Y       = 0,
    parameter int EXIT_X        = 39,
    parameter int EXIT_Y        = 19,
    parameter int SETTLE_CYCLES = 16
`ifdef MAZE_MOVE_REPEAT_EN
    ,
    parameter int REPEAT_CYCLES = 64
`endif
) (
    input  logic                              Clk,
    input  logic                              Reset,
    input  logic [size_y-1:0][0:size_x-1]     left_constraint,
    input  logic [size_y-1:0][0:size_x-1]     right_constraint,
    input  logic [size_y-1:0][0:size_x-1]     up_constraint,
    input  logic [size_y-1:0][0:size_x-1]     down_constraint,
    input  logic [3:0]                        dir_req,
    output logic [$clog2(size_x)-1:0]         player_x,
    output logic [$clog2(size_y)-1:0]         player_y,
    output logic                              moved,
    output logic                              bumped,
    output logic                              busy,
    output logic                              at_exit
);

    localparam int XW = $clog2(size_x);
    localparam int YW = $clog2(size_y);
    localparam int CW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [XW-1:0] X_LAST      = XW'(size_x - 1);
    localparam logic [YW-1:0] Y_LAST      = YW'(size_y - 1);
    localparam logic [XW-1:0] X_START     = XW'(START_X);
    localparam logic [YW-1:0] Y_START     = YW'(START_Y);
    localparam logic [XW-1:0] X_EXIT      = XW'(EXIT_X);
    localparam logic [YW-1:0] Y_EXIT      = YW'(EXIT_Y);
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);

    localparam logic [3:0] DIR_UP    = 4'b1000;
    localparam logic [3:0] DIR_DOWN  = 4'b0100;
    localparam logic [3:0] DIR_LEFT  = 4'b0010;
    localparam logic [3:0] DIR_RIGHT = 4'b0001;

    typedef enum logic [2:0] {IDLE, MOVE, SETTLE, RELEASE, DONE} state_t;

    state_t          state;
    state_t          state_next;
    logic [3:0]      prev_dir;
    logic [3:0]      dir_reg;
    logic [CW-1:0]   settle_cnt;
    logic            new_req;
    logic            req_valid;
    logic            blocked;
    logic [XW-1:0]   next_x;
    logic [YW-1:0]   next_y;

`ifdef MAZE_MOVE_REPEAT_EN
    localparam int RW = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RW-1:0] REPEAT_LAST = RW'(REPEAT_CYCLES - 1);
    logic [RW-1:0]   repeat_cnt;
`endif

    // A press counts only on the rising edge of the request level and must be exactly one-hot.
    assign new_req   = (dir_req != 4'b0000) && (prev_dir == 4'b0000);
    assign req_valid = new_req && $onehot(dir_req);
    assign at_exit   = (player_x == X_EXIT) && (player_y == Y_EXIT);

    always_comb begin
        blocked = 1'b1;
        next_x  = player_x;
        next_y  = player_y;
        case (dir_reg)
            DIR_UP: begin
                blocked = (player_y == '0) || up_constraint[player_y][player_x];
                next_y  = player_y - 1'b1;
            end
            DIR_DOWN: begin
                blocked = (player_y == Y_LAST) || down_constraint[player_y][player_x];
                next_y  = player_y + 1'b1;
            end
            DIR_LEFT: begin
                blocked = (player_x == '0) || left_constraint[player_y][player_x];
                next_x  = player_x - 1'b1;
            end
            DIR_RIGHT: begin
                blocked = (player_x == X_LAST) || right_constraint[player_y][player_x];
                next_x  = player_x + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = MOVE;
            MOVE:    state_next = SETTLE;
            SETTLE:  if (settle_cnt == '0) state_next = at_exit ? DONE : RELEASE;
            RELEASE: begin
                if (dir_req == 4'b0000) begin
                    state_next = IDLE;
                end
`ifdef MAZE_MOVE_REPEAT_EN
                else if ((dir_req == dir_reg) && (repeat_cnt == REPEAT_LAST)) begin
                    state_next = MOVE;
                end
`endif
            end
            DONE:    state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == MOVE) || (state == SETTLE);
    end

    // Position, pulses and counters; constraint bits are only looked at during MOVE.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            player_x   <= X_START;
            player_y   <= Y_START;
            moved      <= 1'b0;
            bumped     <= 1'b0;
            settle_cnt <= '0;
            dir_reg    <= 4'b0000;
            prev_dir   <= 4'b0000;
        end else begin
            prev_dir <= dir_req;
            moved    <= 1'b0;
            bumped   <= 1'b0;
            if ((state == IDLE) && req_valid) begin
                dir_reg <= dir_req;
            end
            if (state == MOVE) begin
                settle_cnt <= SETTLE_LOAD;
                if (blocked) begin
                    bumped <= 1'b1;
                end else begin
                    moved    <= 1'b1;
                    player_x <= next_x;
                    player_y <= next_y;
                end
            end else if ((state == SETTLE) && (settle_cnt != '0)) begin
                settle_cnt <= settle_cnt - 1'b1;
            end
        end
    end

`ifdef MAZE_MOVE_REPEAT_EN
    // Counts consecutive RELEASE cycles with the same direction still held.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            repeat_cnt <= '0;
        end else if ((state == RELEASE) && (dir_req == dir_reg) && (repeat_cnt != REPEAT_LAST)) begin
            repeat_cnt <= repeat_cnt + 1'b1;
        end else begin
            repeat_cnt <= '0;
        end
    end
`endif

endmodule
